// File: rtl/smc_seq.sv
// smc_seq: transistor-channel packet sequencer.
// Takes N_CH beats (w, v_gs, v_ds) per packet and keeps their I_D or
// g_m values in a descending sorted array. Then it reduces the largest
// or the smallest three values to one weighted result.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, w, v_gs,
//   v_ds, mode (beat input); out_valid/out_n (result strobe); err
//   (packet abort strobe).
// Config: define SMC_OUT_HOLD_EN to keep out_n at the last result.
//   Without it, out_n reads 0 whenever out_valid is low.
module smc_seq #(
  parameter int N_CH  = 6,
  parameter int VW    = 3,
  parameter int OUT_W = 2*VW+4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VW-1:0]    w,
  input  logic [VW-1:0]    v_gs,
  input  logic [VW-1:0]    v_ds,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n,
  output logic             err
);

  // w*ov*ov needs 3*VW bits; every per-channel value fits in CW
  localparam int CW  = 3*VW;
  localparam int CTW = $clog2(N_CH);
  localparam int RW  = CW+4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CTW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    srt_q [N_CH];
  logic [CW-1:0]    srt_d [N_CH];
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] out_n_q, out_n_d;

  // per-beat device value
  logic [1:0]    mode_sel;
  logic [VW-1:0] ov;
  logic [CW-1:0] ov_x, vds_x, w_x;
  logic [CW-1:0] tri_f;
  logic          sat;
  logic [CW-1:0] id_v, gm_v, beat_val;

  always_comb begin
    mode_sel = (state_q == S_IDLE) ? mode : mode_q;
    ov       = (v_gs > VW'(1)) ? v_gs - VW'(1) : '0;
    ov_x     = CW'(ov);
    vds_x    = CW'(v_ds);
    w_x      = CW'(w);
    sat      = (ov <= v_ds);
    // only positive (and only used) in triode, where ov > v_ds
    tri_f    = CW'(2) * ov_x * vds_x - vds_x * vds_x;
    if (sat) begin
      id_v = (w_x * ov_x * ov_x) / CW'(3);
      gm_v = (CW'(2) * w_x * ov_x) / CW'(3);
    end else begin
      id_v = (w_x * tri_f) / CW'(3);
      gm_v = (CW'(2) * w_x * vds_x) / CW'(3);
    end
    beat_val = mode_sel[0] ? id_v : gm_v;
  end

  // insertion into the descending array; a fresh packet sees it empty
  logic [CTW-1:0] cnt_eff;
  logic [N_CH-1:0] ge;
  logic [CW-1:0]   srt_ins [N_CH];

  always_comb begin
    cnt_eff = (state_q == S_IDLE) ? '0 : cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      ge[i] = (i < int'(cnt_eff)) && (srt_q[i] >= beat_val);
    end
    srt_ins[0] = ge[0] ? srt_q[0] : beat_val;
    for (int i = 1; i < N_CH; i++) begin
      if (ge[i])
        srt_ins[i] = srt_q[i];
      else if (ge[i-1])
        srt_ins[i] = beat_val;
      else
        srt_ins[i] = srt_q[i-1];
    end
  end

  // reduction of the three selected values, a >= b >= c
  logic [RW-1:0] sa, sb, sc, res;

  always_comb begin
    if (mode_q[1]) begin
      sa = RW'(srt_q[0]);
      sb = RW'(srt_q[1]);
      sc = RW'(srt_q[2]);
    end else begin
      sa = RW'(srt_q[N_CH-3]);
      sb = RW'(srt_q[N_CH-2]);
      sc = RW'(srt_q[N_CH-1]);
    end
    if (mode_q[0])
      res = (RW'(3)*sa + RW'(4)*sb + RW'(5)*sc) / RW'(12);
    else
      res = (sa + sb + sc) / RW'(3);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    srt_d       = srt_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
`ifdef SMC_OUT_HOLD_EN
    out_n_d     = out_n_q;
`else
    out_n_d     = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_LOAD;
          cnt_d   = CTW'(1);
          mode_d  = mode;
          srt_d   = srt_ins;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          srt_d = srt_ins;
          if (cnt_q == CTW'(N_CH-1)) begin
            state_d = S_CALC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CTW'(1);
          end
        end else begin
          // gap inside a packet: drop it
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_CALC: begin
        state_d     = S_OUT;
        out_valid_d = 1'b1;
        out_n_d     = OUT_W'(res);
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_n_q     <= '0;
      for (int i = 0; i < N_CH; i++) srt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      out_n_q     <= out_n_d;
      for (int i = 0; i < N_CH; i++) srt_q[i] <= srt_d[i];
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_seq.sv
// tb_smc_seq: directed bench for smc_seq with a packet-level model.
// Checks every output every cycle plus literal results per packet.
module tb_smc_seq;
  localparam int N     = 6;
  localparam int VW    = 3;
  localparam int OUT_W = 2*VW+4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [VW-1:0]    w, v_gs, v_ds;
  logic [1:0]       mode;
  logic             out_valid;
  logic [OUT_W-1:0] out_n;
  logic             err;

  smc_seq #(.N_CH(N), .VW(VW), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .w(w), .v_gs(v_gs), .v_ds(v_ds), .mode(mode),
    .out_valid(out_valid), .out_n(out_n), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int mval(int wi, int gs, int ds, bit id);
    int o;
    o = (gs > 1) ? gs - 1 : 0;
    if (o <= ds)
      return id ? (wi*o*o)/3 : (2*wi*o)/3;
    return id ? (wi*(2*o*ds - ds*ds))/3 : (2*wi*ds)/3;
  endfunction

  function automatic int pick(int v[$], logic [1:0] m);
    int q[$];
    int a, b, c;
    q = v;
    q.rsort();
    if (m[1]) begin
      a = q[0]; b = q[1]; c = q[2];
    end else begin
      a = q[N-3]; b = q[N-2]; c = q[N-1];
    end
    return m[0] ? (3*a + 4*b + 5*c)/12 : (a + b + c)/3;
  endfunction

  // packet-level model, evaluated on each rising edge
  int         edge_n = 0;
  int         done_edge = -1;
  bit         in_pkt = 0;
  bit         m_init = 0;
  logic [1:0] m_mode = 2'b00;
  int         vals[$];
  int         m_res = 0;
  logic       e_valid = 0, e_err = 0, e_ready = 1;
  int         e_out = 0;

  always @(posedge clk) begin
    edge_n++;
    e_valid = 0;
    e_err   = 0;
    if (reset) begin
      in_pkt = 0;
      vals.delete();
      done_edge = -1;
      e_out   = 0;
      e_ready = 1;
      m_init  = 1;
    end else begin
      if (e_ready && in_valid) begin
        if (!in_pkt) begin
          in_pkt = 1;
          m_mode = mode;
        end
        vals.push_back(mval(int'(w), int'(v_gs), int'(v_ds), m_mode[0]));
        if (vals.size() == N) begin
          m_res = pick(vals, m_mode);
          vals.delete();
          in_pkt = 0;
          done_edge = edge_n;
        end
      end else if (in_pkt && !in_valid) begin
        in_pkt = 0;
        vals.delete();
        e_err = 1;
      end
      if (done_edge >= 0 && edge_n == done_edge + 1) e_valid = 1;
`ifdef SMC_OUT_HOLD_EN
      if (e_valid) e_out = m_res;
`else
      e_out = e_valid ? m_res : 0;
`endif
      e_ready = !(done_edge >= 0 && edge_n <= done_edge + 1);
    end
  end

  // literal expectations written by the driver, read by the checker
  int lit_arr [16];
  int lit_n = 0;
  bit tb_done = 0;

  int tests = 0;
  int fails = 0;
  int lit_rd = 0;
  int err_cnt = 0;
  bit prev_valid = 0;
  bit pinned = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1;
      chk("pin_id_sat", mval(3, 3, 3, 1), 4);
      chk("pin_id_tri", mval(3, 7, 2, 1), 20);
      chk("pin_id_cut", mval(1, 1, 7, 1), 0);
      chk("pin_gm_tri", mval(3, 7, 2, 0), 4);
      chk("pin_gm_sat", mval(6, 3, 3, 0), 8);
    end
    if (m_init) begin
      chk("out_valid", int'(out_valid), int'(e_valid));
      chk("err", int'(err), int'(e_err));
      chk("in_ready", int'(in_ready), int'(e_ready));
      chk("out_n", int'(out_n), e_out);
      if (prev_valid) begin
`ifdef SMC_OUT_HOLD_EN
        chk("hold_out_n", int'(out_n), lit_arr[lit_rd-1]);
`else
        chk("hold_out_n", int'(out_n), 0);
`endif
      end
      if (out_valid) begin
        if (lit_rd < lit_n)
          chk("lit_result", int'(out_n), lit_arr[lit_rd]);
        else
          chk("extra_valid", 1, 0);
        lit_rd++;
      end
      if (err) err_cnt++;
      prev_valid = out_valid;
    end
    if (tb_done) begin
      chk("result_count", lit_rd, lit_n);
      chk("err_count", err_cnt, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic beat(input int a, input int b, input int c,
                      input logic [1:0] m);
    in_valid = 1'b1;
    w    = VW'(a);
    v_gs = VW'(b);
    v_ds = VW'(c);
    mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input int v);
    lit_arr[lit_n] = v;
    lit_n++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    w = '0; v_gs = '0; v_ds = '0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    lit(4);
    for (int i = 0; i < N; i++) beat(3, 3, 3, 2'b11);
    idle(4);

    lit(6);
    for (int i = 1; i <= N; i++) beat(i, 3, 3, 2'b10);
    idle(4);

    lit(2);
    for (int i = 1; i <= N; i++) beat(i, 3, 3, 2'b00);
    idle(4);

    lit(5);
    beat(3, 7, 2, 2'b11);
    for (int i = 0; i < 5; i++) beat(1, 1, 7, 2'b00);
    idle(4);

    lit(1);
    beat(3, 7, 2, 2'b10);
    for (int i = 0; i < 5; i++) beat(1, 1, 7, 2'b01);
    idle(4);

    for (int i = 0; i < 3; i++) beat(3, 3, 3, 2'b11);
    idle(4);
    lit(4);
    for (int i = 0; i < N; i++) beat(3, 3, 3, 2'b11);
    beat(7, 7, 7, 2'b00);
    beat(7, 7, 7, 2'b00);
    idle(4);

    for (int i = 0; i < N; i++) beat(3, 3, 3, 2'b11);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);

    lit(2);
    for (int i = 1; i <= N; i++) beat(i, 3, 3, 2'b00);
    idle(4);

    lit(6);
    for (int i = N; i >= 1; i--) beat(i, 3, 3, 2'b10);
    idle(4);

    tb_done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL timeout checker did not finish");
    $fatal(1);
  end

endmodule
